// File: rtl/lu_writeback.sv
// lu_writeback: writeback stage downstream of logic_unit.
//
// Accepts {result, NZVC, dest, setf} entries over a valid/ready handshake into a
// 2-entry FIFO and commits at most one entry per cycle into a small register
// file and the architectural NZVC flags register.
//
// Ports:
//   clk          clock, all state updates on the rising edge
//   rst          synchronous active-high reset
//   in_valid     logic_unit presents an entry this cycle
//   in_ready     stage can accept an entry this cycle (depends on state only)
//   in_result    result value to write
//   in_NZVC      flags to store verbatim (bit3=N, bit2=Z, bit1=V, bit0=C)
//   in_dest      destination register index
//   in_setf      entry updates the flags register on commit
//   wb_stall     register-file port busy; blocks commit this cycle
//   rd_addr      combinational read address
//   rd_data      regs[rd_addr]
//   flags        architectural NZVC register
//   commit_valid one-cycle registered pulse per committed entry
//   commit_dest  destination of the last commit
//   commit_cnt   committed-entry counter, wraps mod 256
module lu_writeback #(
    parameter int WIDTH = 8,
    parameter int NREGS = 4,
    parameter int AW    = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_result,
    input  logic [3:0]       in_NZVC,
    input  logic [AW-1:0]    in_dest,
    input  logic             in_setf,
    input  logic             wb_stall,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data,
    output logic [3:0]       flags,
    output logic             commit_valid,
    output logic [AW-1:0]    commit_dest,
    output logic [7:0]       commit_cnt
);

    // FIFO storage, indexed by a 1-bit pointer
    logic [WIDTH-1:0] fifo_result [2];
    logic [3:0]       fifo_nzvc   [2];
    logic [AW-1:0]    fifo_dest   [2];
    logic             fifo_setf   [2];
    logic             head;
    logic [1:0]       fifo_count;
    logic [1:0]       fifo_count_d;
    logic             wr_ptr;
    logic             push;
    logic             pop;

    logic [WIDTH-1:0] regs [NREGS];

    // Ready looks only at state, so a same-cycle pop never opens a full FIFO
    assign in_ready = !rst && (fifo_count < 2'd2);
    assign push     = in_valid && in_ready;
    assign pop      = (fifo_count != 2'd0) && !wb_stall;
    // Tail slot: head when empty, the other slot when one entry is held
    assign wr_ptr   = head ^ fifo_count[0];
    assign rd_data  = regs[rd_addr];

    always_comb begin
        fifo_count_d = fifo_count;
        case ({push, pop})
            2'b10:   fifo_count_d = fifo_count + 2'd1;
            2'b01:   fifo_count_d = fifo_count - 2'd1;
            default: fifo_count_d = fifo_count;
        endcase
    end

    // Payload slots need no reset; occupancy is tracked by head/fifo_count
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_result[wr_ptr] <= in_result;
            fifo_nzvc[wr_ptr]   <= in_NZVC;
            fifo_dest[wr_ptr]   <= in_dest;
            fifo_setf[wr_ptr]   <= in_setf;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head         <= 1'b0;
            fifo_count   <= 2'd0;
            flags        <= 4'b0000;
            commit_valid <= 1'b0;
            commit_dest  <= '0;
            commit_cnt   <= 8'd0;
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            fifo_count   <= fifo_count_d;
            commit_valid <= pop;
            if (pop) begin
                regs[fifo_dest[head]] <= fifo_result[head];
                if (fifo_setf[head]) begin
                    flags <= fifo_nzvc[head];
                end
                commit_dest <= fifo_dest[head];
                commit_cnt  <= commit_cnt + 8'd1;
                head        <= ~head;
            end
        end
    end

endmodule

// File: tb/tb_lu_writeback.sv
module tb_lu_writeback;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_result;
    logic [3:0] in_NZVC;
    logic [1:0] in_dest;
    logic       in_setf;
    logic       wb_stall;
    logic [1:0] rd_addr;
    logic [7:0] rd_data;
    logic [3:0] flags;
    logic       commit_valid;
    logic [1:0] commit_dest;
    logic [7:0] commit_cnt;

    int checks = 0;
    int errors = 0;

    lu_writeback dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_result    (in_result),
        .in_NZVC      (in_NZVC),
        .in_dest      (in_dest),
        .in_setf      (in_setf),
        .wb_stall     (wb_stall),
        .rd_addr      (rd_addr),
        .rd_data      (rd_data),
        .flags        (flags),
        .commit_valid (commit_valid),
        .commit_dest  (commit_dest),
        .commit_cnt   (commit_cnt)
    );

    always #10 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_reg(input int idx, input logic [31:0] exp);
        rd_addr = idx[1:0];
        #1;
        chk($sformatf("reg%0d", idx), 32'(rd_data), exp);
    endtask

    // Advance past the next rising edge; sampling happens 1 ns later
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [7:0] r, input logic [3:0] f,
                         input logic [1:0] d, input logic s);
        in_valid  = v;
        in_result = r;
        in_NZVC   = f;
        in_dest   = d;
        in_setf   = s;
    endtask

    initial begin
        rst      = 1'b1;
        wb_stall = 1'b0;
        rd_addr  = 2'd0;
        drive(1'b0, 8'h00, 4'h0, 2'd0, 1'b0);

        // Reset state
        step();
        step();
        chk("rst_ready", 32'(in_ready), 0);
        chk("rst_cvalid", 32'(commit_valid), 0);
        chk("rst_cnt", 32'(commit_cnt), 0);
        chk("rst_flags", 32'(flags), 0);
        rst = 1'b0;
        #1;
        chk("ready_after_rst", 32'(in_ready), 1);

        // Single entry: accept, then commit on the following edge
        drive(1'b1, 8'h00, 4'b0100, 2'd0, 1'b1);
        step();
        drive(1'b0, 8'h00, 4'h0, 2'd0, 1'b0);
        chk("t1_no_commit_yet", 32'(commit_valid), 0);
        chk("t1_cnt0", 32'(commit_cnt), 0);
        step();
        chk("t1_cvalid", 32'(commit_valid), 1);
        chk("t1_flags", 32'(flags), 32'b0100);
        chk("t1_cnt", 32'(commit_cnt), 1);
        chk("t1_cdest", 32'(commit_dest), 0);
        chk_reg(0, 32'h00);
        step();
        chk("t1_pulse_end", 32'(commit_valid), 0);
        chk("t1_cnt_hold", 32'(commit_cnt), 1);

        // Four back-to-back entries, no stall
        drive(1'b1, 8'hFF, 4'b1000, 2'd1, 1'b1);
        step();
        chk("t2_ready1", 32'(in_ready), 1);
        drive(1'b1, 8'hFA, 4'b1000, 2'd2, 1'b1);
        step();
        chk("t2_ready2", 32'(in_ready), 1);
        drive(1'b1, 8'hAA, 4'b1000, 2'd3, 1'b0);
        step();
        chk("t2_ready3", 32'(in_ready), 1);
        chk("t2_flags_mid", 32'(flags), 32'b1000);
        drive(1'b1, 8'h00, 4'b0100, 2'd0, 1'b1);
        step();
        drive(1'b0, 8'h00, 4'h0, 2'd0, 1'b0);
        chk("t2_flags_setf0", 32'(flags), 32'b1000);
        chk("t2_cdest", 32'(commit_dest), 3);
        step();
        chk("t2_flags", 32'(flags), 32'b0100);
        chk("t2_cnt", 32'(commit_cnt), 5);
        chk_reg(0, 32'h00);
        chk_reg(1, 32'hFF);
        chk_reg(2, 32'hFA);
        chk_reg(3, 32'hAA);

        // Stall fills the FIFO; third entry is held off
        wb_stall = 1'b1;
        drive(1'b1, 8'h11, 4'b0001, 2'd1, 1'b1);
        step();
        chk("t3_ready_cnt1", 32'(in_ready), 1);
        drive(1'b1, 8'h22, 4'b0010, 2'd2, 1'b1);
        step();
        chk("t3_ready_full", 32'(in_ready), 0);
        drive(1'b1, 8'h33, 4'b0011, 2'd3, 1'b1);
        step();
        chk("t3_still_full", 32'(in_ready), 0);
        chk("t3_no_commit", 32'(commit_valid), 0);
        chk_reg(1, 32'hFF);
        // Release stall with in_valid high while full: one pop, no accept
        wb_stall = 1'b0;
        step();
        chk("t4_cvalid", 32'(commit_valid), 1);
        chk("t4_ready_reopen", 32'(in_ready), 1);
        chk("t4_flags_a", 32'(flags), 32'b0001);
        chk_reg(1, 32'h11);
        // Push C and pop B together
        step();
        drive(1'b0, 8'h00, 4'h0, 2'd0, 1'b0);
        chk("t4_cdest_b", 32'(commit_dest), 2);
        chk("t4_flags_b", 32'(flags), 32'b0010);
        chk_reg(2, 32'h22);
        step();
        chk("t4_cdest_c", 32'(commit_dest), 3);
        chk("t4_flags_c", 32'(flags), 32'b0011);
        chk("t4_cnt", 32'(commit_cnt), 8);
        chk_reg(3, 32'h33);
        step();
        chk("t4_drained", 32'(commit_valid), 0);
        chk("t4_cnt_hold", 32'(commit_cnt), 8);

        // Reset with two entries buffered discards them
        wb_stall = 1'b1;
        drive(1'b1, 8'h44, 4'b1111, 2'd0, 1'b1);
        step();
        drive(1'b1, 8'h55, 4'b1111, 2'd1, 1'b1);
        step();
        drive(1'b0, 8'h00, 4'h0, 2'd0, 1'b0);
        chk("t5_full", 32'(in_ready), 0);
        rst      = 1'b1;
        wb_stall = 1'b0;
        step();
        chk("t5_cvalid", 32'(commit_valid), 0);
        chk("t5_cnt", 32'(commit_cnt), 0);
        chk("t5_flags", 32'(flags), 0);
        chk("t5_ready_in_rst", 32'(in_ready), 0);
        chk_reg(0, 32'h00);
        chk_reg(1, 32'h00);
        chk_reg(3, 32'h00);
        rst = 1'b0;
        step();
        chk("t5_no_stale_commit", 32'(commit_valid), 0);
        step();
        chk("t5_no_stale_commit2", 32'(commit_valid), 0);
        chk("t5_cnt_after", 32'(commit_cnt), 0);
        chk_reg(1, 32'h00);

        // 256 commits: counter wraps; only the first entry sets flags
        for (int i = 0; i < 256; i++) begin
            if (i == 0) drive(1'b1, i[7:0], 4'b1010, i[1:0], 1'b1);
            else        drive(1'b1, i[7:0], 4'b0101, i[1:0], 1'b0);
            step();
            chk("t6_ready", 32'(in_ready), 1);
        end
        drive(1'b0, 8'h00, 4'h0, 2'd0, 1'b0);
        chk("t6_cnt_ff", 32'(commit_cnt), 32'hFF);
        step();
        chk("t6_cnt_wrap", 32'(commit_cnt), 0);
        chk("t6_cvalid", 32'(commit_valid), 1);
        chk("t6_flags", 32'(flags), 32'b1010);
        chk_reg(0, 32'hFC);
        chk_reg(1, 32'hFD);
        chk_reg(2, 32'hFE);
        chk_reg(3, 32'hFF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
